t_counter_ctrl: RTL and testbench
=================================

T_COUNTER_CTRL -- requirements
Module: t_counter_ctrl

Interface
REQ-001 SHALL have parameter W, default 4: width of the toggle-bit bank (number of T-stage bits).
REQ-002 SHALL have port Ck, input, 1: single clock; all state updates on posedge Ck.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1: request to begin a count run; sampled on posedge Ck in IDLE only.
REQ-005 SHALL have port up, input, 1: direction (1 = increment, 0 = decrement); captured with start.
REQ-006 SHALL have port limit, input, W: terminal count value; captured with start.
REQ-007 SHALL have port T, output, W: per-bit toggle-enable vector driven into the bank this cycle.
REQ-008 SHALL have port Q, output, W: current bank state.
REQ-009 SHALL have port busy, output, 1: high while the state is RUN.
REQ-010 SHALL have port done, output, 1: one-cycle pulse marking run completion.

Function
REQ-011 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-012 In IDLE with start=1 at posedge: lim_r<=limit, dir_r<=up, Q<=0, next state RUN; otherwise hold IDLE and Q.
REQ-013 In RUN with Q==lim_r: T SHALL be all zeros, Q SHALL hold, and next state SHALL be DONE.
REQ-014 In RUN with Q!=lim_r and dir_r=1: T[0]=1 and T[i]=AND(Q[i-1:0]) for i>0.
REQ-015 In RUN with Q!=lim_r and dir_r=0: T[0]=1 and T[i]=AND(~Q[i-1:0]) for i>0.
REQ-016 On each posedge in RUN, Q SHALL update to Q XOR T (toggle semantics: bit flips iff its T=1).
REQ-017 T SHALL be combinational from state, Q, lim_r and dir_r, and SHALL be all zeros in IDLE and DONE.
REQ-018 Arithmetic SHALL be modulo 2^W: up from 2^W-1 wraps to 0; down from 0 wraps to 2^W-1.
REQ-019 In DONE, done=1 for exactly that cycle; next state SHALL be IDLE unconditionally; Q SHALL hold the final value.
REQ-020 start SHALL be ignored in RUN and DONE; a new run SHALL begin no earlier than the first IDLE cycle after DONE.
REQ-021 Run length: RUN SHALL last N+1 cycles, where N = (lim_r - 0) mod 2^W for up and (0 - lim_r) mod 2^W for down; done follows in the next cycle.
REQ-022 limit=0 SHALL give exactly 1 RUN cycle with no toggles, then DONE.
REQ-023 limit and up changing during RUN SHALL have no effect (the captured lim_r and dir_r are used).
REQ-024 busy SHALL equal (state==RUN); done SHALL equal (state==DONE); both SHALL be glitch-free registered-state decodes.

Reset
REQ-025 reset=1 SHALL immediately, without waiting for Ck, force state=IDLE, Q=0, lim_r=0, dir_r=1, busy=0, done=0, T=0.
REQ-026 Reset asserted mid-RUN or in DONE SHALL abort the run with no done pulse.
REQ-027 After reset deasserts, the first start SHALL be honoured at the first posedge at which start=1.

Verification
REQ-028 Up run, W=4: start=1, up=1, limit=5 -> Q steps 0,1,2,3,4,5; busy=1 for 6 cycles; done=1 for one cycle; Q stays 5.
REQ-029 Down run, W=4: start=1, up=0, limit=13 -> T=1111,0001,0011 then 0000; Q steps 0,15,14,13; done pulses once.
REQ-030 Full wrap, W=4: up=1, limit=15 -> 16 RUN cycles; at Q=7, T=1111; done once; Q ends 15.
REQ-031 limit=0 with up=1 -> busy=1 for exactly 1 cycle, T=0 throughout, done pulses, Q=0.
REQ-032 Reset mid-run: up=1, limit=9; assert reset at Q=3 between edges -> Q=0, busy=0 immediately; no done pulse; a later start runs normally.
REQ-033 Start during RUN: pulse start with limit=2 while running toward limit=6 -> run still ends at Q=6; no second run until IDLE.

Source files
------------

// File: rtl/t_counter_ctrl.sv
// Toggle-stage up/down counter with run controller.
// Drives T into a bank of T flops and counts from 0 to a captured limit.
module t_counter_ctrl #(
  parameter int W = 4
) (
  input  logic         Ck,
  input  logic         reset,
  input  logic         start,
  input  logic         up,
  input  logic [W-1:0] limit,
  output logic [W-1:0] T,
  output logic [W-1:0] Q,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [W-1:0] q_q, q_d;
  logic [W-1:0] lim_q, lim_d;
  logic         dir_q, dir_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic [W-1:0] t_d;
  logic         at_lim;
  logic         chain;

  assign at_lim = (q_q == lim_q);

  // Ripple carry/borrow: bit i toggles when all lower bits are 1 (up) or 0 (down).
  always_comb begin
    t_d   = '0;
    chain = 1'b1;
    if (state_q == RUN && !at_lim) begin
      for (int i = 0; i < W; i++) begin
        t_d[i] = chain;
        chain  = chain & (dir_q ? q_q[i] : ~q_q[i]);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    lim_d   = lim_q;
    dir_d   = dir_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          lim_d   = limit;
          dir_d   = up;
          q_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        q_d = q_q ^ t_d;
        if (at_lim) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge Ck or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      q_q     <= '0;
      lim_q   <= '0;
      dir_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      lim_q   <= lim_d;
      dir_q   <= dir_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign T    = t_d;
  assign Q    = q_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_t_counter_ctrl.sv
// Self-checking bench for t_counter_ctrl.
// Reference model counts with modular arithmetic; T is derived as Q ^ next(Q).
module tb_t_counter_ctrl;
  localparam int W = 4;
  localparam int M = 1 << W;

  logic         Ck;
  logic         reset;
  logic         start;
  logic         up;
  logic [W-1:0] limit;
  logic [W-1:0] T;
  logic [W-1:0] Q;
  logic         busy;
  logic         done;

  int total = 0;
  int bad   = 0;

  int   m_ph;
  int   m_q;
  int   m_lim;
  logic m_dir;

  t_counter_ctrl #(.W(W)) dut (
    .Ck(Ck), .reset(reset), .start(start), .up(up),
    .limit(limit), .T(T), .Q(Q), .busy(busy), .done(done)
  );

  initial Ck = 1'b0;
  always #5 Ck = ~Ck;

  function automatic int nxt(int q, logic d);
    return d ? (q + 1) % M : (q + M - 1) % M;
  endfunction

  function automatic logic [W-1:0] exp_t();
    if (m_ph == 1 && m_q != m_lim)
      return W'(m_q ^ nxt(m_q, m_dir));
    return '0;
  endfunction

  function automatic logic [3*W+1:0] exp_all();
    return {(m_ph == 1), (m_ph == 2), exp_t(), W'(m_q)};
  endfunction

  task automatic model_reset();
    m_ph = 0; m_q = 0; m_lim = 0; m_dir = 1'b1;
  endtask

  task automatic model_step(input logic s, input logic u,
                            input logic [W-1:0] l);
    case (m_ph)
      0: if (s) begin
        m_lim = int'(l); m_dir = u; m_q = 0; m_ph = 1;
      end
      1: if (m_q == m_lim) m_ph = 2;
         else m_q = nxt(m_q, m_dir);
      default: m_ph = 0;
    endcase
  endtask

  task automatic tick(input logic s, input logic u,
                      input logic [W-1:0] l);
    @(negedge Ck);
    start = s; up = u; limit = l;
    @(posedge Ck);
    model_step(s, u, l);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; up = 1'b0; limit = '0;
    model_reset();
    #2;
    total++;
    if ({busy, done, T, Q} !== exp_all()) begin
      bad++;
      $display("FAIL reset_state got=%b want=%b",
               {busy, done, T, Q}, exp_all());
    end
    @(negedge Ck);
    reset = 1'b0;
  endtask

  task automatic test_up_run();
    int nb, nd;
    nb = 0; nd = 0;
    tick(1'b1, 1'b1, 4'd5);
    for (int c = 0; c < 40; c++) begin
      total++;
      if ({busy, done, T, Q} !== exp_all()) begin
        bad++;
        $display("FAIL up_cycle c=%0d got=%b want=%b",
                 c, {busy, done, T, Q}, exp_all());
      end
      if (busy) nb++;
      if (done) begin nd++; break; end
      tick(1'b0, 1'($urandom), W'($urandom));
    end
    total++;
    if (nb != 6 || nd != 1 || Q !== 4'd5) begin
      bad++;
      $display("FAIL up_len busy=%0d done=%0d q=%0d want 6 1 5",
               nb, nd, Q);
    end
    tick(1'b0, 1'b1, 4'd0);
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || Q !== 4'd5) begin
      bad++;
      $display("FAIL up_after done=%b busy=%b q=%0d want 0 0 5",
               done, busy, Q);
    end
  endtask

  task automatic test_down_run();
    logic [W-1:0] seen [$];
    logic [W-1:0] want [4];
    want = '{4'b1111, 4'b0001, 4'b0011, 4'b0000};
    tick(1'b1, 1'b0, 4'd13);
    for (int c = 0; c < 40; c++) begin
      total++;
      if ({busy, done, T, Q} !== exp_all()) begin
        bad++;
        $display("FAIL down_cycle c=%0d got=%b want=%b",
                 c, {busy, done, T, Q}, exp_all());
      end
      if (busy) seen.push_back(T);
      if (done) break;
      tick(1'b0, 1'($urandom), W'($urandom));
    end
    total++;
    if (seen.size() != 4 || Q !== 4'd13) begin
      bad++;
      $display("FAIL down_len runs=%0d q=%0d want 4 13",
               seen.size(), Q);
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (seen[i] !== want[i]) begin
          bad++;
          $display("FAIL down_t i=%0d got=%b want=%b",
                   i, seen[i], want[i]);
        end
      end
    end
    tick(1'b0, 1'b0, 4'd0);
  endtask

  task automatic test_full_wrap();
    int nb, nd;
    logic seen7;
    nb = 0; nd = 0; seen7 = 1'b0;
    tick(1'b1, 1'b1, 4'd15);
    for (int c = 0; c < 40; c++) begin
      total++;
      if ({busy, done, T, Q} !== exp_all()) begin
        bad++;
        $display("FAIL wrap_cycle c=%0d got=%b want=%b",
                 c, {busy, done, T, Q}, exp_all());
      end
      if (busy && Q == 4'd7) begin
        seen7 = 1'b1;
        total++;
        if (T !== 4'b1111) begin
          bad++;
          $display("FAIL wrap_t7 got=%b want=1111", T);
        end
      end
      if (busy) nb++;
      if (done) begin nd++; break; end
      tick(1'b0, 1'($urandom), W'($urandom));
    end
    total++;
    if (nb != 16 || nd != 1 || Q !== 4'd15 || !seen7) begin
      bad++;
      $display("FAIL wrap_len busy=%0d done=%0d q=%0d want 16 1 15",
               nb, nd, Q);
    end
    tick(1'b0, 1'b1, 4'd0);
  endtask

  task automatic test_limit_zero();
    int nb, nd, nt;
    nb = 0; nd = 0; nt = 0;
    tick(1'b1, 1'b1, 4'd0);
    for (int c = 0; c < 10; c++) begin
      if (busy) nb++;
      if (T !== 4'd0) nt++;
      if (done) begin nd++; break; end
      tick(1'b0, 1'b1, 4'd7);
    end
    total++;
    if (nb != 1 || nd != 1 || nt != 0 || Q !== 4'd0) begin
      bad++;
      $display("FAIL zero_run busy=%0d done=%0d tnz=%0d q=%0d want 1 1 0 0",
               nb, nd, nt, Q);
    end
    tick(1'b0, 1'b1, 4'd0);
  endtask

  task automatic test_reset_mid_run();
    int nd;
    nd = 0;
    tick(1'b1, 1'b1, 4'd9);
    for (int c = 0; c < 20 && Q != 4'd3; c++)
      tick(1'b0, 1'b1, 4'd9);
    total++;
    if (Q !== 4'd3 || busy !== 1'b1) begin
      bad++;
      $display("FAIL rst_pre q=%0d busy=%b want 3 1", Q, busy);
    end
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    total++;
    if ({busy, done, T, Q} !== exp_all()) begin
      bad++;
      $display("FAIL rst_async got=%b want=%b",
               {busy, done, T, Q}, exp_all());
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge Ck); #1;
      if (done) nd++;
    end
    @(negedge Ck);
    reset = 1'b0;
    total++;
    if (nd != 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rst_hold done_pulses=%0d busy=%b want 0 0", nd, busy);
    end
    tick(1'b1, 1'b0, 4'd14);
    for (int c = 0; c < 10; c++) begin
      total++;
      if ({busy, done, T, Q} !== exp_all()) begin
        bad++;
        $display("FAIL rst_rerun c=%0d got=%b want=%b",
                 c, {busy, done, T, Q}, exp_all());
      end
      if (done) break;
      tick(1'b0, 1'b1, 4'd0);
    end
    total++;
    if (Q !== 4'd14 || done !== 1'b1) begin
      bad++;
      $display("FAIL rst_rerun_end q=%0d done=%b want 14 1", Q, done);
    end
    tick(1'b0, 1'b1, 4'd0);
  endtask

  task automatic test_start_during_run();
    int nb, nd;
    nb = 0; nd = 0;
    tick(1'b1, 1'b1, 4'd6);
    for (int c = 0; c < 40; c++) begin
      total++;
      if ({busy, done, T, Q} !== exp_all()) begin
        bad++;
        $display("FAIL sdr_cycle c=%0d got=%b want=%b",
                 c, {busy, done, T, Q}, exp_all());
      end
      if (busy) nb++;
      if (done) begin nd++; break; end
      tick(1'b1, 1'b0, 4'd2);
    end
    total++;
    if (nb != 7 || nd != 1 || Q !== 4'd6) begin
      bad++;
      $display("FAIL sdr_len busy=%0d done=%0d q=%0d want 7 1 6",
               nb, nd, Q);
    end
    tick(1'b0, 1'b0, 4'd2);
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || Q !== 4'd6) begin
      bad++;
      $display("FAIL sdr_idle busy=%b done=%b q=%0d want 0 0 6",
               busy, done, Q);
    end
  endtask

  task automatic test_random();
    logic s;
    for (int c = 0; c < 600; c++) begin
      s = ($urandom_range(0, 3) == 0);
      tick(s, 1'($urandom), W'($urandom));
      total++;
      if ({busy, done, T, Q} !== exp_all()) begin
        bad++;
        $display("FAIL rand_cycle c=%0d got=%b want=%b",
                 c, {busy, done, T, Q}, exp_all());
      end
    end
  endtask

  initial begin
    test_reset();
    test_up_run();
    test_down_run();
    test_full_wrap();
    test_limit_zero();
    test_reset_mid_run();
    test_start_during_run();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
